// File: rtl/uart_command_decoder.sv
// rtl/uart_command_decoder.sv - serial command responder: word assembly, upload/download, CPU reset control
module uart_command_decoder #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [31:0]           mem_rdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  cmd_error
);
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_OPCODE, S_ADDR_START, S_ADDR_END,
        S_UPLOAD, S_DL_READ, S_DL_CAPTURE, S_DL_SEND
    } state_t;

    state_t                r_state, w_state_n;
    logic [1:0]            r_byte_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_word_valid;
    logic [ADDR_WIDTH-1:0] r_cur_addr, w_cur_addr_n;
    logic [ADDR_WIDTH-1:0] r_end_addr, w_end_addr_n;
    logic                  r_is_dl, w_is_dl_n;
    logic [DATA_WIDTH-1:0] r_dl_word, w_dl_word_n;
    logic [1:0]            r_tx_idx, w_tx_idx_n;
    logic                  r_tx_gap;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_n;
    logic [31:0]           r_mem_wdata, w_mem_wdata_n;
    logic                  r_mem_we, w_mem_we_n;
    logic                  r_mem_re, w_mem_re_n;
    logic                  r_cpu_rst_n, w_cpu_rst_n_n;
    logic                  r_cmd_error, w_cmd_error_n;

    logic                  w_in_dl;
    logic                  w_tx_fire;
    logic [7:0]            w_tx_byte;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [ADDR_WIDTH-1:0] w_cur_next;

    assign w_in_dl     = (r_state == S_DL_READ) || (r_state == S_DL_CAPTURE) || (r_state == S_DL_SEND);
    assign w_tx_fire   = (r_state == S_DL_SEND) && !r_tx_gap && tx_ready;
    assign w_word_addr = ADDR_WIDTH'(r_word);
    assign w_cur_next  = r_cur_addr + ADDR_WIDTH'(4);

    // Byte counter survives everything but reset, so framing stays aligned to the host stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt   <= 2'd0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (rx_valid && !w_in_dl) begin
                r_word     <= {r_word[DATA_WIDTH-9:0], rx_data};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) r_word_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_end_addr  <= '0;
            r_is_dl     <= 1'b0;
            r_dl_word   <= '0;
            r_tx_idx    <= 2'd0;
            r_tx_gap    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_cpu_rst_n <= 1'b1;
            r_cmd_error <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cur_addr  <= w_cur_addr_n;
            r_end_addr  <= w_end_addr_n;
            r_is_dl     <= w_is_dl_n;
            r_dl_word   <= w_dl_word_n;
            r_tx_idx    <= w_tx_idx_n;
            r_tx_gap    <= w_tx_fire;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_re    <= w_mem_re_n;
            r_cpu_rst_n <= w_cpu_rst_n_n;
            r_cmd_error <= w_cmd_error_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cur_addr_n  = r_cur_addr;
        w_end_addr_n  = r_end_addr;
        w_is_dl_n     = r_is_dl;
        w_dl_word_n   = r_dl_word;
        w_tx_idx_n    = r_tx_idx;
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
        w_mem_we_n    = 1'b0;
        w_mem_re_n    = 1'b0;
        w_cpu_rst_n_n = r_cpu_rst_n;
        w_cmd_error_n = 1'b0;
        case (r_state)
            S_IDLE: if (r_word_valid) begin
                if (r_word == '0) w_state_n = S_OPCODE;
                else              w_cmd_error_n = 1'b1;
            end
            S_OPCODE: if (r_word_valid) begin
                case (r_word)
                    32'h0: w_state_n = S_OPCODE;
                    32'h2: begin w_state_n = S_ADDR_START; w_is_dl_n = 1'b0; end
                    32'h3: begin w_state_n = S_ADDR_START; w_is_dl_n = 1'b1; end
                    32'h4: begin w_state_n = S_IDLE; w_cpu_rst_n_n = 1'b1; end
                    32'h5: begin w_state_n = S_IDLE; w_cpu_rst_n_n = 1'b0; end
                    default: begin w_state_n = S_IDLE; w_cmd_error_n = 1'b1; end
                endcase
            end
            S_ADDR_START: if (r_word_valid) begin
                w_cur_addr_n = w_word_addr;
                w_state_n    = S_ADDR_END;
            end
            // Range is validated only once both addresses are known.
            S_ADDR_END: if (r_word_valid) begin
                if (w_word_addr <= r_cur_addr || w_word_addr[1:0] != 2'b00 || r_cur_addr[1:0] != 2'b00) begin
                    w_cmd_error_n = 1'b1;
                    w_state_n     = S_IDLE;
                end else begin
                    w_end_addr_n = w_word_addr;
                    if (r_is_dl) begin
                        w_state_n    = S_DL_READ;
                        w_mem_re_n   = 1'b1;
                        w_mem_addr_n = r_cur_addr;
                    end else begin
                        w_state_n = S_UPLOAD;
                    end
                end
            end
            S_UPLOAD: if (r_word_valid) begin
                w_mem_we_n    = 1'b1;
                w_mem_addr_n  = r_cur_addr;
                w_mem_wdata_n = r_word;
                w_cur_addr_n  = w_cur_next;
                if (w_cur_next == r_end_addr) w_state_n = S_IDLE;
            end
            S_DL_READ: w_state_n = S_DL_CAPTURE;
            S_DL_CAPTURE: begin
                w_dl_word_n = mem_rdata;
                w_tx_idx_n  = 2'd0;
                w_state_n   = S_DL_SEND;
            end
            S_DL_SEND: if (w_tx_fire) begin
                w_tx_idx_n = r_tx_idx + 2'd1;
                if (r_tx_idx == 2'd3) begin
                    w_cur_addr_n = w_cur_next;
                    if (w_cur_next == r_end_addr) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_state_n    = S_DL_READ;
                        w_mem_re_n   = 1'b1;
                        w_mem_addr_n = w_cur_next;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_tx_idx)
            2'd0:    w_tx_byte = r_dl_word[31:24];
            2'd1:    w_tx_byte = r_dl_word[23:16];
            2'd2:    w_tx_byte = r_dl_word[15:8];
            default: w_tx_byte = r_dl_word[7:0];
        endcase
    end

    assign tx_data   = (r_state == S_DL_SEND) ? w_tx_byte : 8'h00;
    assign tx_start  = w_tx_fire;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = (r_state != S_IDLE);
    assign cmd_error = r_cmd_error;
endmodule

// File: tb/tb_uart_command_decoder.sv
// tb/tb_uart_command_decoder.sv - directed table-driven bench for uart_command_decoder
module tb_uart_command_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        cpu_rst_n;
    logic        busy;
    logic        cmd_error;

    uart_command_decoder #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cpu_rst_n(cpu_rst_n), .busy(busy), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int err_cnt = 0;
    int tx_viol = 0;
    int tx_cnt = 0;
    int re_cycle = -1;
    int first_tx = -1;
    bit prev_fire = 1'b0;
    bit [31:0] mem [256];
    logic [7:0]  tx_q[$];
    logic [63:0] we_q[$];

    // Memory with one-cycle read latency, and a transmitter that drops ready after the gap cycle.
    always @(posedge clk) begin
        cyc++;
        if (mem_re) mem_rdata <= mem[mem_addr[9:2]];
        if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            we_q.push_back({mem_addr, mem_wdata});
        end
        if (cmd_error) err_cnt++;
        if (mem_re && re_cycle < 0) re_cycle = cyc;
        if (tx_start) begin
            if (!tx_ready || prev_fire) tx_viol++;
            if (first_tx < 0) first_tx = cyc;
            tx_q.push_back(tx_data);
            tx_cnt = 5;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
        end
        prev_fire = tx_start;
        tx_ready <= (tx_cnt == 0 || tx_cnt == 5);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    typedef struct {
        int               n;
        logic [5:0][31:0] w;
        int               exp_err;
        logic             exp_cpu;
        logic             exp_busy;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [31:0] a, b, c, d, e, f,
                                input int err, input logic cpu, input logic bsy);
        vec_t v;
        v.n = n;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e; v.w[5] = f;
        v.exp_err = err; v.exp_cpu = cpu; v.exp_busy = bsy;
        return v;
    endfunction

    vec_t vt[11];
    logic [31:0] dat[4];

    initial begin
        int e0;
        int w0;
        logic [31:0] wexp;
        logic [7:0]  bexp;

        vt[0]  = mk(2, 0, 5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        vt[1]  = mk(2, 0, 4, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        vt[2]  = mk(6, 0, 0, 0, 0, 0, 4, 0, 1'b1, 1'b0);
        vt[3]  = mk(2, 0, 7, 0, 0, 0, 0, 1, 1'b1, 1'b0);
        vt[4]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 1'b1, 1'b0);
        vt[5]  = mk(4, 0, 2, 32'h420, 32'h400, 0, 0, 1, 1'b1, 1'b0);
        vt[6]  = mk(4, 0, 2, 32'h402, 32'h420, 0, 0, 1, 1'b1, 1'b0);
        vt[7]  = mk(4, 0, 3, 32'h400, 32'h3FC, 0, 0, 1, 1'b1, 1'b0);
        vt[8]  = mk(4, 0, 2, 32'h400, 32'h400, 0, 0, 1, 1'b1, 1'b0);
        vt[9]  = mk(4, 0, 5, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        vt[10] = mk(1, 4, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        dat[0] = 32'h12345678; dat[1] = 32'hAABBAABB; dat[2] = 32'hCCCCCCCC; dat[3] = 32'h11112222;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 1);
        check("rst_busy", busy, 0);
        check("rst_cmd_error", cmd_error, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // cpu_rst_n changes the cycle after the opcode word_valid
        send_word(32'h0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk); rx_data = 8'h05; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        check("cpu_hold_before", cpu_rst_n, 1);
        check("busy_in_opcode", busy, 1);
        @(posedge clk); #1;
        check("cpu_fall", cpu_rst_n, 0);
        check("busy_after_op5", busy, 0);

        // cmd_error is a single-cycle pulse the cycle after the bad word_valid
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        @(negedge clk); rx_data = 8'h01; rx_valid = 1'b1;
        @(posedge clk); #1 rx_valid = 1'b0;
        check("err_before", cmd_error, 0);
        @(posedge clk); #1;
        check("err_pulse", cmd_error, 1);
        @(posedge clk); #1;
        check("err_clear", cmd_error, 0);

        for (int i = 0; i < 11; i++) begin
            e0 = err_cnt;
            w0 = we_q.size();
            for (int k = 0; k < vt[i].n; k++) send_word(vt[i].w[k]);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_err", i), err_cnt - e0, vt[i].exp_err);
            check($sformatf("vec%0d_cpu", i), cpu_rst_n, vt[i].exp_cpu);
            check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
            check($sformatf("vec%0d_we", i), we_q.size() - w0, 0);
        end

        // Upload eight words into 0x400..0x41C
        we_q.delete();
        e0 = err_cnt;
        send_word(0); send_word(2); send_word(32'h400); send_word(32'h420);
        for (int k = 0; k < 8; k++) send_word(dat[k % 4]);
        repeat (6) @(negedge clk);
        check("up_count", we_q.size(), 8);
        for (int k = 0; k < 8 && k < we_q.size(); k++) begin
            wexp = 32'h400 + 4 * k;
            check($sformatf("up_addr%0d", k), we_q[k][63:32], wexp);
            check($sformatf("up_data%0d", k), we_q[k][31:0], dat[k % 4]);
        end
        check("up_busy", busy, 0);
        check("up_err", err_cnt - e0, 0);

        // Download the same range; two stray bytes during DL must be ignored
        tx_q.delete();
        tx_viol = 0; re_cycle = -1; first_tx = -1;
        e0 = err_cnt;
        send_word(0); send_word(3); send_word(32'h400); send_word(32'h420);
        repeat (2) @(negedge clk);
        send_byte(8'hFF); send_byte(8'hFF);
        for (int i = 0; i < 3000 && (tx_q.size() < 32 || busy); i++) @(negedge clk);
        check("dl_count", tx_q.size(), 32);
        for (int k = 0; k < 32 && k < tx_q.size(); k++) begin
            wexp = dat[(k / 4) % 4] >> (24 - 8 * (k % 4));
            bexp = wexp[7:0];
            check($sformatf("dl_byte%0d", k), tx_q[k], bexp);
        end
        check("dl_tx_viol", tx_viol, 0);
        check("dl_latency_ok", (first_tx - re_cycle) >= 2, 1);
        check("dl_busy", busy, 0);
        send_word(0); send_word(5);
        repeat (4) @(negedge clk);
        check("dl_drop_cpu", cpu_rst_n, 0);
        check("dl_drop_err", err_cnt - e0, 0);

        // Reset in the middle of an upload with a partial word pending
        we_q.delete();
        send_word(0); send_word(2); send_word(32'h400); send_word(32'h420);
        send_word(32'h55555555); send_word(32'h66666666); send_word(32'h77777777);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (2) @(negedge clk);
        check("pre_rst_writes", we_q.size(), 3);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_cpu", cpu_rst_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        rst = 1'b1;
        we_q.delete();
        e0 = err_cnt;
        send_word(0); send_word(2); send_word(32'h400); send_word(32'h404);
        send_word(32'hDEADBEEF);
        repeat (6) @(negedge clk);
        check("post_rst_count", we_q.size(), 1);
        if (we_q.size() > 0) begin
            check("post_rst_addr", we_q[0][63:32], 32'h400);
            check("post_rst_data", we_q[0][31:0], 32'hDEADBEEF);
        end
        check("post_rst_err", err_cnt - e0, 0);
        check("post_rst_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
